// File: rtl/nibble_serial_adder_controller.sv
// Sequences a WIDTH-bit add/subtract through an external 4-bit full adder, one nibble at a time.
// Each nibble is held on the adder for SETTLE_CYCLES cycles, then its sum and carry are captured.
module nibble_serial_adder_controller #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [3:0]       adder_a,
   output logic [3:0]       adder_b,
   output logic             adder_c0,
   input  logic [3:0]       adder_s,
   input  logic             adder_c4,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             negative
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sub_q, carry_q;
   logic             busy_q, done_q, cout_q, zero_q, neg_q;
   logic             drive;
   logic [3:0]       nib_a, nib_b;

   // Adder inputs are driven only while a nibble is in flight; zero otherwise.
   always_comb begin
      drive    = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
      nib_a    = a_q[{idx_q, 2'b00} +: 4];
      nib_b    = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
      adder_a  = drive ? nib_a : 4'h0;
      adder_b  = drive ? nib_b : 4'h0;
      adder_c0 = drive & carry_q;
      result_d = result_q;
      result_d[{idx_q, 2'b00} +: 4] = adder_s;
   end

   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && start) begin
         a_q <= operand_a;
         b_q <= operand_b;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sub_q    <= op_sub;
                  carry_q  <= op_sub;
                  idx_q    <= '0;
                  cnt_q    <= CNT_LOAD;
                  busy_q   <= 1'b1;
                  result_q <= '0;
                  cout_q   <= 1'b0;
                  zero_q   <= 1'b0;
                  neg_q    <= 1'b0;
                  state_q  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) state_q <= S_CAPTURE;
               else             cnt_q   <= cnt_q - CNT_W'(1);
            end
            S_CAPTURE: begin
               result_q <= result_d;
               carry_q  <= adder_c4;
               if (idx_q == LAST_IDX) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cout_q  <= adder_c4;
                  zero_q  <= (result_d == '0);
                  neg_q   <= result_d[WIDTH-1];
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_SETTLE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = cout_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

endmodule

// File: tb/tb_nibble_serial_adder_controller.sv
// Directed bench for nibble_serial_adder_controller; the bench plays the external 4-bit adder.
module tb_nibble_serial_adder_controller;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        op_sub = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic [3:0]  adder_a, adder_b, adder_s;
   logic        adder_c0, adder_c4;
   logic        busy, done, carry_out, zero, negative;
   logic [31:0] result;
   logic [4:0]  sum;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int fail_cnt = 0;

   logic [3:0] seen_a [8];
   logic [3:0] seen_b [8];
   logic       seen_c0 [8];

   nibble_serial_adder_controller #(.WIDTH(32), .SETTLE_CYCLES(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .op_sub    (op_sub),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .adder_a   (adder_a),
      .adder_b   (adder_b),
      .adder_c0  (adder_c0),
      .adder_s   (adder_s),
      .adder_c4  (adder_c4),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .negative  (negative)
   );

   always #5 clk = ~clk;

   assign sum      = {1'b0, adder_a} + {1'b0, adder_b} + {4'b0, adder_c0};
   assign adder_s  = sum[3:0];
   assign adder_c4 = sum[4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Launches one operation and follows it to the DONE cycle and the IDLE cycle after it.
   // Sample k is taken just before rising edge k, counting the start-sampling edge as edge 0.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input int inj, input logic [31:0] exp_r,
                        input logic exp_c, input logic exp_z, input logic exp_n);
      int bad;
      bad = 0;
      operand_a = a;
      operand_b = b;
      op_sub    = sub;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_result_cleared"}, result, 32'h0);
      for (int k = 1; k <= 24; k++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         if ((k - 1) % 3 == 0) begin
            seen_a[(k - 1) / 3]  = adder_a;
            seen_b[(k - 1) / 3]  = adder_b;
            seen_c0[(k - 1) / 3] = adder_c0;
         end
         if (k == inj) begin
            start     = 1'b1;
            operand_a = ~a;
            operand_b = 32'h0BAD_F00D;
            op_sub    = ~sub;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      check({tag, "_busy_window_errors"}, bad, 0);
      check({tag, "_done_at_25"}, done, 1);
      check({tag, "_busy_in_done"}, busy, 0);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_carry_out"}, carry_out, exp_c);
      check({tag, "_zero"}, zero, exp_z);
      check({tag, "_negative"}, negative, exp_n);
      check({tag, "_adder_idle_in_done"}, {23'b0, adder_a, adder_b, adder_c0}, 0);
      tick();
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_adder_idle_after"}, {23'b0, adder_a, adder_b, adder_c0}, 0);
   endtask

   initial begin
      int cnt;
      logic [6:0] c0v;

      // Reset state.
      tick();
      tick();
      check("rst_flags", {busy, done, carry_out, zero, negative}, 0);
      check("rst_result", result, 0);
      check("rst_adder", {adder_a, adder_b, adder_c0}, 0);
      reset_n = 1'b1;

      do_op("add5p3", 32'h5, 32'h3, 1'b0, 0, 32'h8, 1'b0, 1'b0, 1'b0);

      do_op("addovf", 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 32'h0, 1'b1, 1'b1, 1'b0);
      c0v = {seen_c0[7], seen_c0[6], seen_c0[5], seen_c0[4], seen_c0[3], seen_c0[2], seen_c0[1]};
      check("addovf_c0_nib1to7", c0v, 7'h7F);
      check("addovf_c0_nib0", seen_c0[0], 0);

      do_op("sub5m7", 32'h5, 32'h7, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      check("sub5m7_b_inverted", seen_b[0], 4'h8);
      check("sub5m7_c0_nib0", seen_c0[0], 1);

      do_op("subeq", 32'h1234_5678, 32'h1234_5678, 1'b1, 0, 32'h0, 1'b1, 1'b1, 1'b0);

      do_op("addf8", 32'hF8, 32'h08, 1'b0, 0, 32'h100, 1'b0, 1'b0, 1'b0);
      check("addf8_nib0_drive", {seen_a[0], seen_b[0], 3'b0, seen_c0[0]}, 12'h880);
      check("addf8_nib1_drive", {seen_a[1], seen_b[1], 3'b0, seen_c0[1]}, 12'hF01);

      // Start with new operands mid-operation must be ignored.
      do_op("ignore", 32'h1111_1111, 32'h2222_2222, 1'b0, 10, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
      tick();
      check("ignore_no_queued_op", busy, 0);

      // Start held high restarts on the first IDLE cycle after DONE.
      operand_a = 32'h1;
      operand_b = 32'h1;
      op_sub    = 1'b0;
      start     = 1'b1;
      tick();
      for (int k = 1; k <= 24; k++) tick();
      check("held_first_done", done, 1);
      check("held_first_result", result, 32'h2);
      tick();
      check("held_idle_gap", busy, 0);
      tick();
      check("held_restart_busy", busy, 1);
      start = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      check("held_second_done_within_bound", done, 1);
      check("held_second_result", result, 32'h2);
      tick();

      // Asynchronous reset in the middle of an operation.
      operand_a = 32'h0F0F_0F0F;
      operand_b = 32'h0101_0101;
      op_sub    = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 12; k++) tick();
      reset_n = 1'b0;
      #1;
      check("midrst_busy_done", {busy, done}, 0);
      check("midrst_result", result, 0);
      check("midrst_flags", {carry_out, zero, negative}, 0);
      check("midrst_adder", {adder_a, adder_b, adder_c0}, 0);
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         if (done !== 1'b0 || busy !== 1'b0) cnt++;
         tick();
      end
      check("midrst_no_done_or_busy", cnt, 0);
      check("midrst_result_held_zero", result, 0);

      do_op("add2p2", 32'h2, 32'h2, 1'b0, 0, 32'h4, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder_controller.md
NIBBLE_SERIAL_ADDER_CONTROLLER -- requirements
Module: nibble_serial_adder_controller

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4 (NIBBLES = WIDTH/4).
REQ-003 Parameter SETTLE_CYCLES, default 2, clock cycles each nibble is held on the adder before capture; SHALL be >= 1.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request new operation; sampled only in IDLE.
REQ-007 op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-008 operand_a  input  WIDTH  first operand; sampled with start.
REQ-009 operand_b  input  WIDTH  second operand; sampled with start.
REQ-010 adder_a  output  4  nibble A to external 4-bit full adder.
REQ-011 adder_b  output  4  nibble B (inverted when subtracting) to adder.
REQ-012 adder_c0  output  1  carry-in to adder.
REQ-013 adder_s  input  4  adder sum.
REQ-014 adder_c4  input  1  adder carry-out.
REQ-015 busy  output  1  high from cycle after start acceptance until DONE exits.
REQ-016 done  output  1  one-cycle pulse, result valid.
REQ-017 result  output  WIDTH  registered result; held until next acceptance or reset.
REQ-018 carry_out  output  1  final adder_c4 (subtract: 1 = no borrow).
REQ-019 zero  output  1  result == 0.
REQ-020 negative  output  1  result[WIDTH-1].

Function
REQ-021 States SHALL be IDLE, SETTLE, CAPTURE, DONE.
REQ-022 IDLE: start=1 SHALL latch operands and op_sub, clear nibble index to 0, load carry register with op_sub, load settle counter, go to SETTLE.
REQ-023 SETTLE: adder_a = A[4i+3:4i], adder_b = B nibble XOR {4{op_sub}}, adder_c0 = carry register; stays SETTLE_CYCLES cycles, then CAPTURE.
REQ-024 CAPTURE: SHALL write adder_s into result nibble i and adder_c4 into carry register; adder inputs remain driven; if i = NIBBLES-1 go DONE, else i+1 and SETTLE.
REQ-025 DONE: done=1 for exactly one cycle; carry_out, zero, negative updated from final values and valid in this cycle; next state IDLE.
REQ-026 Latency: done SHALL assert NIBBLES*(SETTLE_CYCLES+1)+1 rising edges after the edge sampling start (25 for defaults).
REQ-027 result SHALL equal (A + B) mod 2^WIDTH or (A - B) mod 2^WIDTH; computation solely via the external adder.
REQ-028 start while busy SHALL be ignored; latched operands and sequence unaffected.
REQ-029 In IDLE and DONE, adder_a, adder_b, adder_c0 SHALL be 0.
REQ-030 result SHALL be cleared to 0 on start acceptance; partial nibbles visible during operation are not valid until done.
REQ-031 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, busy=0, done=0, result=0, carry_out=0, zero=0, negative=0, adder outputs 0, index and counters 0, including mid-operation.
REQ-033 After reset_n rises, the first start SHALL be accepted no earlier than the next rising edge.

Verification
REQ-034 Add 0x00000005 + 0x00000003 -> result 0x00000008, carry_out 0, zero 0, negative 0, done at edge 25, busy high edges 1-24.
REQ-035 Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out 1, zero 1; adder_c0 = 1 for nibbles 1-7.
REQ-036 Sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry_out 0, negative 1; sub 0x12345678 - 0x12345678 -> result 0, carry_out 1, zero 1.
REQ-037 Add 0x000000F8 + 0x00000008: nibble 0 drives a=8,b=8,c0=0; nibble 1 drives a=F,b=0,c0=1 -> result 0x00000100.
REQ-038 start with new operands at edge 10 of a running add -> ignored, original result delivered at edge 25.
REQ-039 reset_n low at edge 12 of a running operation -> busy 0, done never pulses, result 0; subsequent add 2+2 -> 0x00000004.
